// File: rtl/rgb_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : rgb_frame_reader
// Brief    : Streams a packed 24-bit RGB frame out of SRAM into a pixel FIFO
//            with valid/ready handshake and credit-based read throttling.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_frame_reader #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter int          PIXELS     = 76800,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_R,
    output logic [7:0]  pix_G,
    output logic [7:0]  pix_B,
    output logic        pix_first
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [17:0]      c_last_addr  = 18'(RGB_BASE + 3 * PIXELS / 2 - 1);
    localparam logic [16:0]      c_pixels     = 17'(PIXELS);
    localparam logic [CNT_W:0]   c_credit_lim = (CNT_W + 1)'(FIFO_DEPTH - 2);
    localparam logic [PTR_W-1:0] c_ptr_last   = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_phase;
    logic [16:0]        r_pix_cnt;
    logic [CNT_W-1:0]   r_inflight;
    logic [1:0]         r_tag_v;
    logic [1:0]         r_tag_ph0;
    logic [1:0]         r_tag_ph1;
    logic [7:0]         r_r0;
    logic [7:0]         r_g0;
    logic [7:0]         r_r1;

    logic [23:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_first;
    logic               r_first_pend;
    logic [17:0]        r_addr;

    logic               w_start_ok;
    logic               w_issue;
    logic               w_issue_p0;
    logic               w_last_word;
    logic               w_credit_ok;
    logic               w_push;
    logic               w_pop;
    logic [23:0]        w_push_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    // Throttle on pixels already promised to the FIFO so a whole pair always fits.
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_inflight}) <= c_credit_lim;
    assign w_last_word = (r_phase == 2'd2) && (r_pix_cnt == c_pixels);
    assign w_issue_p0  = w_issue && (r_phase == 2'd0);
    assign w_push      = r_tag_v[1] && (r_tag_ph1 != 2'd0);
    assign w_pop       = pix_valid && pix_ready;

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        w_start_ok  = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if ((r_phase != 2'd0) || w_credit_ok) begin
                    w_issue = 1'b1;
                end
                if (w_issue && w_last_word) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_inflight == '0) && (r_count == '0) && (r_tag_v == 2'b00)) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address, phase and frame pixel counter.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_addr    <= RGB_BASE;
            r_phase   <= 2'd0;
            r_pix_cnt <= '0;
        end else if (w_start_ok) begin
            r_addr    <= RGB_BASE;
            r_phase   <= 2'd0;
            r_pix_cnt <= '0;
        end else if (w_issue) begin
            if (r_addr != c_last_addr) begin
                r_addr <= r_addr + 18'd1;
            end
            r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
            if (w_issue_p0) begin
                r_pix_cnt <= r_pix_cnt + 17'd2;
            end
        end
    end

    // Read tags line up with the two-cycle SRAM latency.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_tag_v   <= 2'b00;
            r_tag_ph0 <= 2'd0;
            r_tag_ph1 <= 2'd0;
            r_r0      <= 8'd0;
            r_g0      <= 8'd0;
            r_r1      <= 8'd0;
        end else begin
            r_tag_v   <= {r_tag_v[0], w_issue};
            r_tag_ph0 <= r_phase;
            r_tag_ph1 <= r_tag_ph0;
            if (r_tag_v[1]) begin
                case (r_tag_ph1)
                    2'd0: begin
                        r_r0 <= SRAM_read_data[15:8];
                        r_g0 <= SRAM_read_data[7:0];
                    end
                    2'd1:    r_r1 <= SRAM_read_data[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign w_push_data = (r_tag_ph1 == 2'd1) ? {r_r0, r_g0, SRAM_read_data[15:8]}
                                             : {r_r1, SRAM_read_data};

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue_p0, w_push})
                2'b10:   r_inflight <= r_inflight + CNT_W'(2);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                2'b11:   r_inflight <= r_inflight + CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_first      <= 1'b0;
            r_first_pend <= 1'b0;
        end else if (w_start_ok) begin
            r_first      <= 1'b0;
            r_first_pend <= 1'b1;
        end else if (w_push && r_first_pend) begin
            r_first      <= 1'b1;
            r_first_pend <= 1'b0;
        end else if (w_pop) begin
            r_first      <= 1'b0;
        end
    end

    assign SRAM_address = r_addr;
    assign SRAM_we_n    = 1'b1;
    assign pix_valid    = (r_count != '0);
    assign pix_first    = r_first;
    // Gating keeps the colour outputs at zero while empty and out of reset.
    assign pix_R        = pix_valid ? r_mem[r_rd_ptr][23:16] : 8'd0;
    assign pix_G        = pix_valid ? r_mem[r_rd_ptr][15:8]  : 8'd0;
    assign pix_B        = pix_valid ? r_mem[r_rd_ptr][7:0]   : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_rgb_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_frame_reader
// Brief    : Scoreboard bench for rgb_frame_reader on a short frame that ends
//            exactly at the top SRAM word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_frame_reader;
    localparam logic [17:0] BASE  = 18'd260344;
    localparam int          NPIX  = 1200;
    localparam int          DEPTH = 8;
    localparam logic [17:0] LAST  = 18'd262143;

    logic        CLOCK_50_I = 1'b0;
    logic        Resetn     = 1'b0;
    logic        start      = 1'b0;
    logic        pix_ready  = 1'b0;
    logic        done;
    logic        busy;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data = 16'd0;
    logic [15:0] sram_p1 = 16'd0;
    logic        pix_valid;
    logic [7:0]  pix_R;
    logic [7:0]  pix_G;
    logic [7:0]  pix_B;
    logic        pix_first;

    int          checks    = 0;
    int          failures  = 0;
    int          n_pops    = 0;
    int          n_done    = 0;
    int          n_first   = 0;
    int          max_count = 0;
    logic [23:0] first_val = 24'd0;
    logic [24:0] exp_q [$];

    rgb_frame_reader #(
        .RGB_BASE   (BASE),
        .PIXELS     (NPIX),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLOCK_50_I     (CLOCK_50_I),
        .Resetn         (Resetn),
        .start          (start),
        .done           (done),
        .busy           (busy),
        .SRAM_address   (SRAM_address),
        .SRAM_we_n      (SRAM_we_n),
        .SRAM_read_data (SRAM_read_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_R          (pix_R),
        .pix_G          (pix_G),
        .pix_B          (pix_B),
        .pix_first      (pix_first)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    function automatic logic [15:0] sram_word(input logic [17:0] a);
        if (a == BASE)         return 16'h1122;
        if (a == BASE + 18'd1) return 16'h3344;
        if (a == BASE + 18'd2) return 16'h5566;
        return {a[7:0] ^ 8'h5A, a[17:10] ^ a[7:0] ^ 8'hC3};
    endfunction

    // Two-cycle SRAM: address in cycle t, data visible in cycle t+2.
    always @(posedge CLOCK_50_I) begin
        sram_p1        <= sram_word(SRAM_address);
        SRAM_read_data <= sram_p1;
    end

    // {first, R, G, B} for pixel p taken straight from the packed layout.
    function automatic logic [24:0] exp_pix(input int p);
        logic [17:0] a;
        logic [15:0] w0, w1, w2;
        a  = BASE + 18'(3 * (p / 2));
        w0 = sram_word(a);
        w1 = sram_word(a + 18'd1);
        w2 = sram_word(a + 18'd2);
        if (p % 2 == 0) return {p == 0, w0[15:8], w0[7:0], w1[15:8]};
        return {1'b0, w1[7:0], w2[15:8], w2[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_start(input bit expect_accept);
        @(posedge CLOCK_50_I); #1;
        start = 1'b1;
        if (expect_accept) begin
            for (int p = 0; p < NPIX; p++) exp_q.push_back(exp_pix(p));
        end
        @(posedge CLOCK_50_I); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int k;
        d0 = n_done;
        k  = 0;
        while (n_done == d0 && k < budget) begin
            @(posedge CLOCK_50_I); #1;
            k++;
        end
        chk(name, 32'(n_done != d0), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"},  32'(done),         32'd0);
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_valid"}, 32'(pix_valid),    32'd0);
        chk({tag, "_first"}, 32'(pix_first),    32'd0);
        chk({tag, "_rgb"},   32'({pix_R, pix_G, pix_B}), 32'd0);
        chk({tag, "_addr"},  32'(SRAM_address), 32'(BASE));
        chk({tag, "_we_n"},  32'(SRAM_we_n),    32'd1);
    endtask

    // Monitor: scoreboard pops, head stability, address progression, done count.
    initial begin
        logic [24:0] e;
        logic [23:0] held;
        logic [17:0] prev_addr;
        bit          hold_v;
        bit          prev_busy;
        hold_v    = 1'b0;
        prev_busy = 1'b0;
        held      = 24'd0;
        prev_addr = 18'd0;
        forever begin
            @(negedge CLOCK_50_I);
            if (!Resetn) begin
                hold_v    = 1'b0;
                prev_busy = 1'b0;
            end else begin
                chk("we_n_high", 32'(SRAM_we_n), 32'd1);
                if (int'(dut.r_count) > max_count) max_count = int'(dut.r_count);
                if (hold_v && pix_valid) chk("head_stable", 32'({pix_R, pix_G, pix_B}), 32'(held));
                if (prev_busy && busy) begin
                    chk("addr_step", 32'((SRAM_address == prev_addr || SRAM_address == prev_addr + 18'd1)
                                         && SRAM_address <= LAST), 32'd1);
                end
                if (done) n_done++;
                if (pix_valid && pix_ready) begin
                    n_pops++;
                    chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("pixel", 32'({pix_first, pix_R, pix_G, pix_B}), 32'(e));
                    end
                    if (pix_first) begin
                        n_first++;
                        first_val = {pix_R, pix_G, pix_B};
                    end
                end
                hold_v    = pix_valid && !pix_ready;
                held      = {pix_R, pix_G, pix_B};
                prev_busy = busy;
                prev_addr = SRAM_address;
            end
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, d0, f0, k;
        logic [17:0] a0;

        repeat (3) @(posedge CLOCK_50_I);
        #1;
        chk_reset_outputs("reset");
        Resetn = 1'b1;

        // Full frame, ready held high, with a stray start mid-frame.
        pix_ready = 1'b1;
        p0 = n_pops; d0 = n_done; f0 = n_first;
        do_start(1'b1);
        repeat (30) @(posedge CLOCK_50_I);
        do_start(1'b0);
        wait_done("t1_done_seen", 5000);
        repeat (3) @(posedge CLOCK_50_I);
        #1;
        chk("t1_pops",      32'(n_pops - p0),   32'(NPIX));
        chk("t1_done_once", 32'(n_done - d0),   32'd1);
        chk("t1_last_addr", 32'(SRAM_address),  32'(LAST));
        chk("t1_busy_low",  32'(busy),          32'd0);
        chk("t1_q_empty",   32'(exp_q.size()),  32'd0);
        chk("t1_first_cnt", 32'(n_first - f0),  32'd1);
        chk("t1_first_val", 32'(first_val),     32'h112233);

        // Back-pressure: FIFO fills, address parks after four pairs.
        pix_ready = 1'b0;
        p0 = n_pops;
        do_start(1'b1);
        repeat (60) @(posedge CLOCK_50_I);
        #1;
        chk("t2_count_full", 32'(dut.r_count), 32'd8);
        chk("t2_valid",      32'(pix_valid),   32'd1);
        chk("t2_addr_park",  32'(SRAM_address), 32'(BASE + 18'd12));
        a0 = SRAM_address;
        repeat (20) @(posedge CLOCK_50_I);
        #1;
        chk("t2_addr_hold",  32'(SRAM_address), 32'(a0));
        chk("t2_head",       32'({pix_first, pix_R, pix_G, pix_B}), 32'h1112233);
        pix_ready = 1'b1;
        wait_done("t2_done_seen", 5000);
        chk("t2_pops",    32'(n_pops - p0),  32'(NPIX));
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Random ready at 50%.
        p0 = n_pops; d0 = n_done;
        do_start(1'b1);
        k = 0;
        while (n_done == d0 && k < 20000) begin
            @(posedge CLOCK_50_I); #1;
            pix_ready = 1'($urandom_range(0, 1));
            k++;
        end
        chk("t3_done_seen", 32'(n_done != d0), 32'd1);
        pix_ready = 1'b1;
        repeat (2) @(posedge CLOCK_50_I);
        #1;
        chk("t3_pops",      32'(n_pops - p0),  32'(NPIX));
        chk("t3_max_count", 32'(max_count <= DEPTH), 32'd1);
        chk("t3_q_empty",   32'(exp_q.size()), 32'd0);

        // Reset mid-frame at pixel 500, then a clean frame.
        p0 = n_pops;
        do_start(1'b1);
        k = 0;
        while ((n_pops - p0) < 500 && k < 5000) begin
            @(posedge CLOCK_50_I); #1;
            k++;
        end
        chk("t4_reached_500", 32'((n_pops - p0) >= 500), 32'd1);
        #4;
        Resetn = 1'b0;
        #1;
        chk_reset_outputs("t4_reset");
        exp_q.delete();
        repeat (2) @(posedge CLOCK_50_I);
        #1;
        Resetn = 1'b1;
        p0 = n_pops; f0 = n_first;
        do_start(1'b1);
        wait_done("t4_done_seen", 5000);
        chk("t4_pops",      32'(n_pops - p0),  32'(NPIX));
        chk("t4_first_cnt", 32'(n_first - f0), 32'd1);
        chk("t4_first_val", 32'(first_val),    32'h112233);
        chk("t4_q_empty",   32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
